// File: rtl/perf_pkg.sv
// Shared definitions for the performance monitor: window states and
// counter/channel index constants.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    FROZEN = 2'd2
  } perf_state_t;

  // Counter slot 0 is the cycle counter; event channel k lives in slot k+1.
  localparam int CYC_IDX = 0;

  localparam int INSN    = 0;
  localparam int CTRL    = 1;
  localparam int MISPRED = 2;

  function automatic int evt_idx(input int ch);
    return ch + CYC_IDX + 1;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with a sticky flag recording any increment
// attempted while already at full scale.
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] MAX_VAL = '1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (en && inc) begin
      if (count == MAX_VAL) begin
        ovf <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Measurement-window performance monitor: counts cycles and per-channel
// events between a start condition and a stop/END_PC condition.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          NUM_EVT    = 3,
  parameter logic [31:0] END_PC     = 32'h1c,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic                         i_clr,
  input  logic                         i_insn_vld,
  input  logic [31:0]                  i_pc_debug,
  input  logic [NUM_EVT-1:0]           i_evt,
  input  logic [$clog2(NUM_EVT+1)-1:0] i_rd_sel,
  output logic [CNT_W-1:0]             o_rd_data,
  output logic [NUM_EVT:0]             o_ovf,
  output logic [1:0]                   o_state,
  output logic                         o_done
);

  perf_state_t state, state_nxt;
  logic        count_en;
  logic        done_nxt;
  logic        end_hit;
  logic [NUM_EVT:0] inc_vec;
  logic [CNT_W-1:0] cnt [0:NUM_EVT];
  logic [31:0]      sel_ext;

  assign end_hit = i_insn_vld && (i_pc_debug == END_PC);
  assign sel_ext = 32'(i_rd_sel);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_done <= done_nxt;
    end
  end

  // Opening and closing cycles are both inside the window; clear overrides all.
  always_comb begin
    state_nxt = state;
    count_en  = 1'b0;
    done_nxt  = 1'b0;
    if (i_clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_start || (AUTO_START && i_insn_vld)) begin
            state_nxt = COUNT;
            count_en  = 1'b1;
          end
        end
        COUNT: begin
          count_en = 1'b1;
          if (i_stop || end_hit) begin
            state_nxt = FROZEN;
            done_nxt  = 1'b1;
          end
        end
        FROZEN: state_nxt = FROZEN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    inc_vec          = '0;
    inc_vec[CYC_IDX] = 1'b1;
    for (int k = 0; k < NUM_EVT; k++) begin
      inc_vec[evt_idx(k)] = i_evt[k];
    end
  end

  for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cnt
    perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .clr     (i_clr),
      .en      (count_en),
      .inc     (inc_vec[g]),
      .count   (cnt[g]),
      .ovf     (o_ovf[g])
    );
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd_data <= '0;
    end else if (sel_ext <= 32'(NUM_EVT)) begin
      o_rd_data <= cnt[i_rd_sel];
    end else begin
      o_rd_data <= '0;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: directed window scenarios on two
// configurations plus a randomized run against a behavioural model.
module tb_perf_monitor;
  import perf_pkg::*;

  localparam int          A_EVT = 4;
  localparam int          A_W   = 8;
  localparam int          M_EVT = 3;
  localparam int          M_W   = 16;
  localparam logic [31:0] ENDPC = 32'h1c;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic             a_start, a_stop, a_clr, a_vld;
  logic [31:0]      a_pc;
  logic [A_EVT-1:0] a_evt;
  logic [2:0]       a_sel;
  logic [A_W-1:0]   a_rd;
  logic [A_EVT:0]   a_ovf;
  logic [1:0]       a_state;
  logic             a_done;

  logic             m_start, m_stop, m_clr, m_vld;
  logic [31:0]      m_pc;
  logic [M_EVT-1:0] m_evt;
  logic [1:0]       m_sel;
  logic [M_W-1:0]   m_rd;
  logic [M_EVT:0]   m_ovf;
  logic [1:0]       m_state;
  logic             m_done;

  int total = 0;
  int bad   = 0;

  // Reference model state for the randomized run on the auto-start instance.
  longint     mcnt [0:A_EVT];
  logic [A_EVT:0] movf;
  int         mst;
  logic       mdone;
  logic [A_W-1:0] mrd;

  always #5 clk = ~clk;

  perf_monitor #(.CNT_W(A_W), .NUM_EVT(A_EVT), .END_PC(ENDPC), .AUTO_START(1'b1)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_start(a_start), .i_stop(a_stop), .i_clr(a_clr),
    .i_insn_vld(a_vld), .i_pc_debug(a_pc), .i_evt(a_evt), .i_rd_sel(a_sel),
    .o_rd_data(a_rd), .o_ovf(a_ovf), .o_state(a_state), .o_done(a_done)
  );

  perf_monitor #(.CNT_W(M_W), .NUM_EVT(M_EVT), .END_PC(ENDPC), .AUTO_START(1'b0)) dut_m (
    .i_clk(clk), .i_reset(reset), .i_start(m_start), .i_stop(m_stop), .i_clr(m_clr),
    .i_insn_vld(m_vld), .i_pc_debug(m_pc), .i_evt(m_evt), .i_rd_sel(m_sel),
    .o_rd_data(m_rd), .o_ovf(m_ovf), .o_state(m_state), .o_done(m_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void bump(input int i);
    if (mcnt[i] == 255) movf[i] = 1'b1;
    else mcnt[i]++;
  endfunction

  function automatic void model_step();
    int sel;
    bit live;
    sel   = int'(a_sel);
    live  = 1'b0;
    mrd   = (sel <= A_EVT) ? A_W'(mcnt[sel]) : '0;
    mdone = 1'b0;
    if (a_clr) begin
      for (int i = 0; i <= A_EVT; i++) mcnt[i] = 0;
      movf = '0;
      mst  = 0;
    end else begin
      if (mst == 0 && (a_start || a_vld)) begin
        live = 1'b1;
        mst  = 1;
      end else if (mst == 1) begin
        live = 1'b1;
        if (a_stop || (a_vld && a_pc == ENDPC)) begin
          mst   = 2;
          mdone = 1'b1;
        end
      end
      if (live) begin
        bump(0);
        for (int k = 0; k < A_EVT; k++) if (a_evt[k]) bump(k + 1);
      end
    end
  endfunction

  task automatic test_reset();
    total++; if (a_state !== 2'd0) begin bad++; $display("[TB] FAIL reset_a_state got=%0d want=0", a_state); end
    total++; if (a_rd !== '0) begin bad++; $display("[TB] FAIL reset_a_rd got=%0d want=0", a_rd); end
    total++; if (a_ovf !== '0) begin bad++; $display("[TB] FAIL reset_a_ovf got=%b want=0", a_ovf); end
    total++; if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_done got=%b want=0", a_done); end
    total++; if (m_state !== 2'd0) begin bad++; $display("[TB] FAIL reset_m_state got=%0d want=0", m_state); end
    #5 reset = 1'b0;
    tick();
    total++; if (a_state !== 2'd0) begin bad++; $display("[TB] FAIL post_reset_idle got=%0d want=0", a_state); end
  endtask

  task automatic test_auto_window();
    for (int i = 0; i < 10; i++) begin
      a_vld = 1'b1;
      a_evt = '0;
      a_evt[INSN] = 1'b1;
      a_pc = (i == 9) ? ENDPC : 32'h100 + 32'(4 * i);
      tick();
      if (i == 0) begin
        total++; if (a_state !== 2'd1) begin bad++; $display("[TB] FAIL auto_open got=%0d want=1", a_state); end
      end
    end
    total++; if (a_state !== 2'd2) begin bad++; $display("[TB] FAIL auto_frozen got=%0d want=2", a_state); end
    total++; if (a_done !== 1'b1) begin bad++; $display("[TB] FAIL auto_done got=%b want=1", a_done); end
    a_vld = 1'b0; a_evt = '0; a_sel = 3'd0;
    tick();
    total++; if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL auto_done_pulse got=%b want=0", a_done); end
    total++; if (a_rd !== 8'd10) begin bad++; $display("[TB] FAIL auto_cycles got=%0d want=10", a_rd); end
    a_sel = 3'd1;
    tick();
    total++; if (a_rd !== 8'd10) begin bad++; $display("[TB] FAIL auto_insn got=%0d want=10", a_rd); end
    a_sel = 3'd2;
    tick();
    total++; if (a_rd !== 8'd0) begin bad++; $display("[TB] FAIL auto_ctrl got=%0d want=0", a_rd); end
  endtask

  task automatic test_idle_endpc();
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    a_vld = 1'b1; a_pc = ENDPC;
    tick();
    total++; if (a_state !== 2'd1) begin bad++; $display("[TB] FAIL idle_endpc_state got=%0d want=1", a_state); end
    total++; if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL idle_endpc_done got=%b want=0", a_done); end
    a_vld = 1'b0; a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    total++; if (a_done !== 1'b1) begin bad++; $display("[TB] FAIL stop_done got=%b want=1", a_done); end
    a_sel = 3'd0;
    tick();
    total++; if (a_rd !== 8'd2) begin bad++; $display("[TB] FAIL idle_endpc_cycles got=%0d want=2", a_rd); end
  endtask

  task automatic test_saturation();
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    a_start = 1'b1; a_evt = '0; a_evt[CTRL] = 1'b1; a_sel = 3'd0;
    tick();
    a_start = 1'b0;
    repeat (298) tick();
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0; a_evt = '0;
    total++; if (a_state !== 2'd2) begin bad++; $display("[TB] FAIL sat_state got=%0d want=2", a_state); end
    total++; if (a_ovf !== 5'b00101) begin bad++; $display("[TB] FAIL sat_ovf got=%b want=00101", a_ovf); end
  endtask

  task automatic test_sel_sweep();
    logic [A_W-1:0] exp_rd [0:5];
    exp_rd = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0};
    for (int s = 0; s <= A_EVT + 1; s++) begin
      a_sel = 3'(s);
      #1;
      if (s > 0) begin
        total++; if (a_rd !== exp_rd[s-1]) begin bad++; $display("[TB] FAIL sweep_hold%0d got=%0d want=%0d", s, a_rd, exp_rd[s-1]); end
      end
      tick();
      total++; if (a_rd !== exp_rd[s]) begin bad++; $display("[TB] FAIL sweep_sel%0d got=%0d want=%0d", s, a_rd, exp_rd[s]); end
    end
  endtask

  task automatic test_clr_stop();
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    a_start = 1'b1; a_evt = 4'b1111;
    tick();
    a_start = 1'b0;
    repeat (3) tick();
    a_clr = 1'b1; a_stop = 1'b1;
    tick();
    a_clr = 1'b0; a_stop = 1'b0; a_evt = '0;
    total++; if (a_state !== 2'd0) begin bad++; $display("[TB] FAIL clrstop_state got=%0d want=0", a_state); end
    total++; if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL clrstop_done got=%b want=0", a_done); end
    total++; if (a_ovf !== '0) begin bad++; $display("[TB] FAIL clrstop_ovf got=%b want=0", a_ovf); end
    tick();
    total++; if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL clrstop_done_late got=%b want=0", a_done); end
    for (int s = 0; s <= A_EVT; s++) begin
      a_sel = 3'(s);
      tick();
      total++; if (a_rd !== 8'd0) begin bad++; $display("[TB] FAIL clrstop_cnt%0d got=%0d want=0", s, a_rd); end
    end
  endtask

  task automatic test_reset_mid();
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    a_start = 1'b1; a_evt = 4'b0011; a_sel = 3'd0;
    tick();
    a_start = 1'b0;
    repeat (49) tick();
    tick();
    total++; if (a_rd !== 8'd50) begin bad++; $display("[TB] FAIL mid_pre_reset got=%0d want=50", a_rd); end
    #3 reset = 1'b1;
    #1;
    total++; if (a_state !== 2'd0) begin bad++; $display("[TB] FAIL mid_reset_state got=%0d want=0", a_state); end
    total++; if (a_rd !== 8'd0) begin bad++; $display("[TB] FAIL mid_reset_rd got=%0d want=0", a_rd); end
    total++; if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_done got=%b want=0", a_done); end
    #1 reset = 1'b0;
    a_evt = '0; a_sel = 3'd1;
    tick();
    total++; if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL mid_no_done got=%b want=0", a_done); end
    a_sel = 3'd2;
    tick();
    total++; if (a_rd !== 8'd0) begin bad++; $display("[TB] FAIL mid_cnt_cleared got=%0d want=0", a_rd); end
  endtask

  task automatic test_manual_start();
    m_clr = 1'b1; tick(); m_clr = 1'b0;
    m_vld = 1'b1; m_evt = '0; m_evt[INSN] = 1'b1; m_pc = 32'h200; m_sel = 2'd0;
    repeat (5) tick();
    total++; if (m_state !== 2'd0) begin bad++; $display("[TB] FAIL man_idle got=%0d want=0", m_state); end
    total++; if (m_rd !== 16'd0) begin bad++; $display("[TB] FAIL man_idle_cnt got=%0d want=0", m_rd); end
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    total++; if (m_state !== 2'd1) begin bad++; $display("[TB] FAIL man_open got=%0d want=1", m_state); end
    repeat (4) tick();
    m_stop = 1'b1;
    tick();
    m_stop = 1'b0; m_vld = 1'b0; m_evt = '0;
    total++; if (m_done !== 1'b1) begin bad++; $display("[TB] FAIL man_done got=%b want=1", m_done); end
    tick();
    total++; if (m_rd !== 16'd6) begin bad++; $display("[TB] FAIL man_cycles got=%0d want=6", m_rd); end
    m_sel = 2'd1;
    tick();
    total++; if (m_rd !== 16'd6) begin bad++; $display("[TB] FAIL man_insn got=%0d want=6", m_rd); end
    m_start = 1'b1; m_stop = 1'b1;
    tick();
    m_start = 1'b0; m_stop = 1'b0;
    total++; if (m_state !== 2'd2) begin bad++; $display("[TB] FAIL man_frozen_hold got=%0d want=2", m_state); end
    total++; if (m_done !== 1'b0) begin bad++; $display("[TB] FAIL man_frozen_done got=%b want=0", m_done); end
    m_sel = 2'd0;
    tick();
    total++; if (m_rd !== 16'd6) begin bad++; $display("[TB] FAIL man_frozen_cnt got=%0d want=6", m_rd); end
  endtask

  task automatic test_random();
    for (int i = 0; i <= A_EVT; i++) mcnt[i] = 0;
    movf = '0; mst = 0;
    a_clr = 1'b1; a_start = 1'b0; a_stop = 1'b0; a_vld = 1'b0; a_evt = '0;
    model_step();
    tick();
    for (int n = 0; n < 600; n++) begin
      a_clr   = ($urandom_range(0, 39) == 0);
      a_start = ($urandom_range(0, 15) == 0);
      a_stop  = ($urandom_range(0, 23) == 0);
      a_vld   = 1'($urandom_range(0, 1));
      a_pc    = ($urandom_range(0, 5) == 0) ? ENDPC : 32'h1000 + 32'($urandom_range(0, 255) * 4);
      a_evt   = A_EVT'($urandom);
      a_sel   = 3'($urandom);
      model_step();
      tick();
      total++; if (a_state !== 2'(mst)) begin bad++; $display("[TB] FAIL rnd_state n=%0d got=%0d want=%0d", n, a_state, mst); end
      total++; if (a_done !== mdone) begin bad++; $display("[TB] FAIL rnd_done n=%0d got=%b want=%b", n, a_done, mdone); end
      total++; if (a_ovf !== movf) begin bad++; $display("[TB] FAIL rnd_ovf n=%0d got=%b want=%b", n, a_ovf, movf); end
      total++; if (a_rd !== mrd) begin bad++; $display("[TB] FAIL rnd_rd n=%0d got=%0d want=%0d", n, a_rd, mrd); end
    end
  endtask

  initial begin
    a_start = 1'b0; a_stop = 1'b0; a_clr = 1'b0; a_vld = 1'b0;
    a_pc = 32'h0; a_evt = '0; a_sel = '0;
    m_start = 1'b0; m_stop = 1'b0; m_clr = 1'b0; m_vld = 1'b0;
    m_pc = 32'h0; m_evt = '0; m_sel = '0;
    #2;
    test_reset();
    test_auto_window();
    test_idle_endpc();
    test_saturation();
    test_sel_sweep();
    test_clr_stop();
    test_reset_mid();
    test_manual_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter CNT_W, default 32, width of every counter (legal 8..64).
REQ-002 Parameter NUM_EVT, default 3, number of event channels (ch0 insn-valid, ch1 ctrl, ch2 mispred by convention; legal 1..16).
REQ-003 Parameter END_PC, default 32'h1c, PC that terminates a measurement window.
REQ-004 Parameter AUTO_START, default 1, window opens on first valid instruction when 1, on i_start only when 0.
REQ-005 i_clk  input  1  single clock, all state updates on rising edge.
REQ-006 i_reset  input  1  reset, asynchronous, active-high.
REQ-007 i_start  input  1  open window (IDLE only).
REQ-008 i_stop  input  1  close window immediately.
REQ-009 i_clr  input  1  zero all counters and flags, return to IDLE.
REQ-010 i_insn_vld  input  1  retiring-instruction valid, qualifies i_pc_debug.
REQ-011 i_pc_debug  input  32  PC of retiring instruction.
REQ-012 i_evt  input  NUM_EVT  per-channel event strobes, one count per cycle when high.
REQ-013 i_rd_sel  input  $clog2(NUM_EVT+1)  counter select: 0 = cycle counter, k = event channel k-1.
REQ-014 o_rd_data  output  CNT_W  registered value of selected counter.
REQ-015 o_ovf  output  NUM_EVT+1  sticky saturation flag per counter, same indexing as i_rd_sel.
REQ-016 o_state  output  2  current FSM state encoding.
REQ-017 o_done  output  1  single-cycle pulse on COUNT->FROZEN transition.

Function
REQ-018 FSM states IDLE(0), COUNT(1), FROZEN(2); encoding 3 unreachable, decodes to IDLE.
REQ-019 IDLE->COUNT when i_start, or when AUTO_START=1 and i_insn_vld; the opening cycle is counted.
REQ-020 COUNT->FROZEN when i_stop, or when i_insn_vld and i_pc_debug==END_PC; the closing cycle is counted (inclusive window).
REQ-021 FROZEN holds all counters until i_clr; i_start and i_stop ignored in FROZEN.
REQ-022 In COUNT, cycle counter increments every cycle; event counter k increments on each cycle i_evt[k] is high.
REQ-023 Counters saturate at 2**CNT_W-1, never wrap; the increment that would overflow sets the matching o_ovf bit.
REQ-024 Priority on same cycle: i_clr > i_stop/END_PC > i_start; i_clr in any state zeroes counters and o_ovf next cycle, state IDLE, no o_done.
REQ-025 i_clr in COUNT suppresses counting in that cycle.
REQ-026 o_rd_data = counter[i_rd_sel] registered, 1-cycle latency; out-of-range select returns 0.
REQ-027 o_done asserts for exactly one cycle, the cycle after the FROZEN-entry edge, coincident with o_state==2.
REQ-028 i_insn_vld with END_PC while IDLE does not open and close in one cycle; only the IDLE->COUNT rule applies.

Reset
REQ-029 i_reset asserted asynchronously forces state IDLE, all counters 0, o_ovf 0, o_rd_data 0, o_done 0.
REQ-030 Reset mid-window discards the window; no o_done generated.
REQ-031 Reset deassertion synchronous to i_clk by the integrating top; block takes first update on the first rising edge after deassertion.

Structure
REQ-032 Package perf_pkg holds state enum (IDLE/COUNT/FROZEN), CYC_IDX=0 constant, and the channel-index constants INSN/CTRL/MISPRED.
REQ-033 One sub-module perf_sat_counter (CNT_W, inputs clr/en/inc, outputs count/ovf), instantiated NUM_EVT+1 times by generate.
REQ-034 No simulation-only constructs; block is synthesizable and replaces print-based measurement in benches by reading o_rd_data.

Verification
REQ-035 AUTO_START=1: i_insn_vld at cycle 0, insn valid every cycle, END_PC at 10th insn -> cycle=10, ch0=10, o_done one pulse, o_state=2.
REQ-036 CNT_W=8: 300 cycles in COUNT with ch1 high -> cycle and ch1 read 255, o_ovf[0] and o_ovf[2] set, ch0 unaffected.
REQ-037 i_clr and i_stop same cycle in COUNT -> state IDLE, all counters 0, no o_done.
REQ-038 i_reset asserted mid-cycle after 50 COUNT cycles -> counters 0 and state IDLE before next clock edge.
REQ-039 AUTO_START=0: insn traffic in IDLE -> counters stay 0; i_start then 5 cycles then i_stop -> cycle=6.
REQ-040 i_rd_sel swept 0..NUM_EVT+1 in FROZEN -> each value appears one cycle later; index NUM_EVT+1 reads 0.
